// File: rtl/pixel_stream_pkg.sv
// Shared pixel-stream definitions for the video sink and the pixel generator.
// Provides default grid geometry, the receive FSM state type, the RGB byte
// layout inside a 24-bit pixel and the alive/dead threshold helper.
package pixel_stream_pkg;

  localparam int unsigned X_SIZE         = 1280;
  localparam int unsigned Y_SIZE         = 720;
  localparam int unsigned WORDS_PER_LINE = X_SIZE * 3 / 4;

  localparam logic [9:0]  THRESH = 10'd384;

  // Byte positions inside a 24-bit pixel
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    WAIT_SOF,
    RECV,
    DRAIN,
    WRITE
  } rx_state_t;

  // Cell is alive when the 10-bit channel sum reaches the threshold
  function automatic logic cell_of(input logic [23:0] px, input logic [9:0] thresh);
    logic [9:0] sum;
    sum = {2'b00, px[R_LSB +: 8]} + {2'b00, px[G_LSB +: 8]} + {2'b00, px[B_LSB +: 8]};
    return (sum >= thresh);
  endfunction

endpackage

// File: rtl/grid_stream_receiver_if.sv
// AXI4-Stream video input bundle.
//   tdata  32  packed pixel bytes
//   tkeep   4  byte enables (sink ignores them)
//   tvalid  1  word valid
//   tready  1  sink accepts word
//   tlast   1  last word of a line
//   tuser   1  first word of a frame
interface grid_stream_receiver_if;

  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);

endinterface

// File: rtl/rgb24_unpacker.sv
// 32->24 bit gearbox plus threshold. Three stream words carry four pixels;
// phase selects which pixel(s) the current word completes.
//   clk, rst_n   clock, asynchronous active-low reset
//   word         current stream word
//   phase        0..2 position of word within its 3-word group
//   fire         word is consumed this cycle (updates residual bytes)
//   cell_a       cell of the first (or only) pixel completed
//   cell_b       cell of the second pixel (phase 2 only)
//   n_cells      number of cells produced (1 or 2)
module rgb24_unpacker #(
  parameter logic [9:0] THRESH = pixel_stream_pkg::THRESH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word,
  input  logic [1:0]  phase,
  input  logic        fire,
  output logic        cell_a,
  output logic        cell_b,
  output logic [1:0]  n_cells
);
  import pixel_stream_pkg::*;

  logic [15:0] residual;
  logic [23:0] px_a;
  logic [23:0] px_b;

  always_comb begin
    px_a    = word[23:0];
    px_b    = '0;
    n_cells = 2'd1;
    unique case (phase)
      2'd0: px_a = word[23:0];
      2'd1: px_a = {word[15:0], residual[7:0]};
      2'd2: begin
        px_a    = {word[7:0], residual[15:0]};
        px_b    = word[31:8];
        n_cells = 2'd2;
      end
      default: ;
    endcase
  end

  assign cell_a = cell_of(px_a, THRESH);
  assign cell_b = cell_of(px_b, THRESH);

  // Only bytes carried into the next phase are kept; phase 0 always
  // overwrites them, so no clear is needed at line start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residual <= '0;
    end else if (fire) begin
      unique case (phase)
        2'd0:    residual <= {8'h00, word[31:24]};
        2'd1:    residual <= word[31:16];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/grid_stream_receiver.sv
// AXI4-Stream video sink that thresholds packed RGB pixels into 1-bit cells
// and writes each completed X_SIZE-cell line to grid memory.
//   in_stream_aclk   sole clock
//   periph_resetn    asynchronous active-low reset
//   in_stream        video stream input (slave modport)
//   line_data        assembled line, cell x at bit [X_SIZE-1-x]
//   line_addr        row index of line_data
//   line_wr_valid    line_data/line_addr valid for writing
//   line_wr_ready    memory writer accepts the line
//   frame_done       pulse on the handshake of the last row
//   err_count        saturating count of framing errors
module grid_stream_receiver #(
  parameter int unsigned X_SIZE = pixel_stream_pkg::X_SIZE,
  parameter int unsigned Y_SIZE = pixel_stream_pkg::Y_SIZE,
  parameter logic [9:0]  THRESH = pixel_stream_pkg::THRESH
) (
  input  logic                   in_stream_aclk,
  input  logic                   periph_resetn,
  grid_stream_receiver_if.slave  in_stream,
  output logic [X_SIZE-1:0]      line_data,
  output logic [9:0]             line_addr,
  output logic                   line_wr_valid,
  input  logic                   line_wr_ready,
  output logic                   frame_done,
  output logic [15:0]            err_count
);
  import pixel_stream_pkg::*;

  localparam int unsigned LINE_WORDS = X_SIZE * 3 / 4;
  localparam int unsigned XIW        = $clog2(X_SIZE);
  localparam int unsigned WCW        = $clog2(LINE_WORDS);

  rx_state_t         state, state_next;
  logic [XIW-1:0]    x, x_next, x_e;
  logic [9:0]        y, y_next, y_e;
  logic [WCW-1:0]    wc, wc_next, wc_e;
  logic [1:0]        phase, phase_next, phase_e;
  logic [X_SIZE-1:0] cells, cells_next, cells_e;
  logic [15:0]       err_next;
  logic [16:0]       err_sum;
  logic [1:0]        err_inc;
  logic              tready_q;

  logic              accept, start, sof_err, process;
  logic              cell_a, cell_b;
  logic [1:0]        n_cells;
  logic [XIW-1:0]    idx_a, idx_b;
  logic              unused_tkeep;

  assign unused_tkeep = ^in_stream.tkeep;

  assign accept = in_stream.tvalid && tready_q;

  // A tuser word always begins row 0 from scratch; only the genuine first
  // word of a frame is exempt from counting as a framing error.
  assign start   = accept && in_stream.tuser;
  assign sof_err = start && (state != WAIT_SOF) &&
                   !((state == RECV) && (wc == '0) && (y == '0));
  assign process = accept && ((state == RECV) || start);

  assign x_e     = start ? '0 : x;
  assign y_e     = start ? '0 : y;
  assign wc_e    = start ? '0 : wc;
  assign phase_e = start ? '0 : phase;
  assign cells_e = start ? '0 : cells;

  assign idx_a = XIW'(X_SIZE - 1) - x_e;
  assign idx_b = XIW'(X_SIZE - 2) - x_e;

  rgb24_unpacker #(.THRESH(THRESH)) u_unpack (
    .clk     (in_stream_aclk),
    .rst_n   (periph_resetn),
    .word    (in_stream.tdata),
    .phase   (phase_e),
    .fire    (process),
    .cell_a  (cell_a),
    .cell_b  (cell_b),
    .n_cells (n_cells)
  );

  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    wc_next    = wc;
    phase_next = phase;
    cells_next = cells;
    err_inc    = {1'b0, sof_err};

    if (process) begin
      // Cells are cleared at every line start, so a short line leaves the
      // unreceived tail at zero without further work.
      cells_next        = cells_e;
      cells_next[idx_a] = cell_a;
      if (n_cells == 2'd2) begin
        cells_next[idx_b] = cell_b;
      end
      y_next     = y_e;
      x_next     = x_e + XIW'(n_cells);
      wc_next    = wc_e + WCW'(1);
      phase_next = (phase_e == 2'd2) ? 2'd0 : phase_e + 2'd1;
      if (in_stream.tlast) begin
        if (wc_e != WCW'(LINE_WORDS - 1)) begin
          err_inc = err_inc + 2'd1;
        end
        state_next = WRITE;
      end else if (wc_e == WCW'(LINE_WORDS - 1)) begin
        err_inc    = err_inc + 2'd1;
        state_next = DRAIN;
      end else begin
        state_next = RECV;
      end
    end else begin
      unique case (state)
        WAIT_SOF: ;
        RECV:     ;
        DRAIN: begin
          if (accept && in_stream.tlast) begin
            state_next = WRITE;
          end
        end
        WRITE: begin
          if (line_wr_ready) begin
            if (y == 10'(Y_SIZE - 1)) begin
              y_next     = '0;
              state_next = WAIT_SOF;
            end else begin
              y_next     = y + 10'd1;
              x_next     = '0;
              wc_next    = '0;
              phase_next = '0;
              cells_next = '0;
              state_next = RECV;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign err_sum  = {1'b0, err_count} + 17'(err_inc);
  assign err_next = err_sum[16] ? '1 : err_sum[15:0];

  always_ff @(posedge in_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state     <= WAIT_SOF;
      x         <= '0;
      y         <= '0;
      wc        <= '0;
      phase     <= '0;
      cells     <= '0;
      err_count <= '0;
      tready_q  <= 1'b0;
    end else begin
      state     <= state_next;
      x         <= x_next;
      y         <= y_next;
      wc        <= wc_next;
      phase     <= phase_next;
      cells     <= cells_next;
      err_count <= err_next;
      tready_q  <= (state_next != WRITE);
    end
  end

  assign in_stream.tready = tready_q;
  assign line_data        = cells;
  assign line_addr        = y;
  assign line_wr_valid    = (state == WRITE);
  assign frame_done       = line_wr_valid && line_wr_ready && (y == 10'(Y_SIZE - 1));

endmodule

// File: tb/tb_grid_stream_receiver.sv
module tb_grid_stream_receiver;

  localparam int unsigned XS = 16;
  localparam int unsigned YS = 4;
  localparam int unsigned NW = 12;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [XS-1:0]  line_data;
  logic [9:0]     line_addr;
  logic           line_wr_valid;
  logic           line_wr_ready;
  logic           frame_done;
  logic [15:0]    err_count;

  grid_stream_receiver_if sif();

  grid_stream_receiver #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .in_stream_aclk (clk),
    .periph_resetn  (rst_n),
    .in_stream      (sif),
    .line_data      (line_data),
    .line_addr      (line_addr),
    .line_wr_valid  (line_wr_valid),
    .line_wr_ready  (line_wr_ready),
    .frame_done     (frame_done),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [9:0]     wa_q[$];
  logic [XS-1:0]  wd_q[$];
  int unsigned    wr_total = 0;
  int unsigned    fd_total = 0;

  logic [23:0]    pix [XS];
  logic [31:0]    wbuf [NW];

  // Inputs change just after posedge, so negedge sees the next handshake
  always @(negedge clk) begin
    if (rst_n && line_wr_valid && line_wr_ready) begin
      wa_q.push_back(line_addr);
      wd_q.push_back(line_data);
      wr_total++;
    end
    if (frame_done) fd_total++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_pix(input logic [23:0] even_px, input logic [23:0] odd_px);
    for (int unsigned i = 0; i < XS; i++) pix[i] = i[0] ? odd_px : even_px;
  endtask

  // Expected cells: 1001 0101 0101 0101 = 16'h9555
  task automatic pattern_line();
    set_pix(24'h000000, 24'hFFFFFF);
    pix[0] = 24'h808080;  // 384 -> 1
    pix[1] = 24'h7F7F7F;  // 381 -> 0
    pix[2] = 24'hFF0000;  // 255 -> 0
    pix[3] = 24'hFFFF00;  // 510 -> 1
    pix[4] = 24'h000000;  // 0
    pix[5] = 24'hFFFFFF;  // 1
    pix[6] = 24'h80807F;  // 383 -> 0
    pix[7] = 24'hC0C000;  // 384 -> 1
  endtask

  task automatic pack_line();
    for (int unsigned g = 0; g < XS / 4; g++) begin
      wbuf[3*g]   = {pix[4*g+1][7:0],  pix[4*g]};
      wbuf[3*g+1] = {pix[4*g+2][15:0], pix[4*g+1][23:8]};
      wbuf[3*g+2] = {pix[4*g+3],       pix[4*g+2][23:16]};
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic user);
    int unsigned n;
    n = 0;
    sif.tdata  = d;
    sif.tvalid = 1'b1;
    sif.tlast  = last;
    sif.tuser  = user;
    while (!sif.tready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!sif.tready) check_eq("tready_wait", {31'b0, sif.tready}, 32'd1);
    @(posedge clk); #1;
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
    sif.tuser  = 1'b0;
  endtask

  task automatic send_line(input int unsigned n, input logic sof);
    pack_line();
    for (int unsigned i = 0; i < n; i++)
      send_word((i < NW) ? wbuf[i] : 32'hFFFF_FFFF, i == n - 1, sof && (i == 0));
  endtask

  task automatic expect_write(input string tag, input logic [9:0] a, input logic [XS-1:0] d);
    int unsigned n;
    n = 0;
    while (wa_q.size() == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (wa_q.size() == 0) begin
      check_eq({tag, "_present"}, 32'(wa_q.size()), 32'd1);
    end else begin
      check_eq({tag, "_addr"}, 32'(wa_q.pop_front()), 32'(a));
      check_eq({tag, "_data"}, 32'(wd_q.pop_front()), 32'(d));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    line_wr_ready = 1'b1;
    sif.tdata     = '0;
    sif.tkeep     = 4'hF;
    sif.tvalid    = 1'b0;
    sif.tlast     = 1'b0;
    sif.tuser     = 1'b0;

    #22;
    check_eq("rst_tready",   {31'b0, sif.tready},    32'd0);
    check_eq("rst_valid",    {31'b0, line_wr_valid}, 32'd0);
    check_eq("rst_frame",    {31'b0, frame_done},    32'd0);
    check_eq("rst_err",      32'(err_count),         32'd0);
    check_eq("rst_data",     32'(line_data),         32'd0);
    check_eq("rst_addr",     32'(line_addr),         32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    // Words before the first SOF are dropped
    set_pix(24'hFFFFFF, 24'hFFFFFF);
    send_line(3, 1'b0);
    repeat (4) @(posedge clk); #1;
    check_eq("presof_writes", wr_total, 32'd0);
    check_eq("presof_err",    32'(err_count), 32'd0);

    // Clean frame
    pattern_line();                        send_line(NW, 1'b1);
    set_pix(24'hFFFFFF, 24'hFFFFFF);       send_line(NW, 1'b0);
    set_pix(24'h000000, 24'h000000);       send_line(NW, 1'b0);
    set_pix(24'hFFFFFF, 24'h000000);       send_line(NW, 1'b0);
    expect_write("f0_l0", 10'd0, 16'h9555);
    expect_write("f0_l1", 10'd1, 16'hFFFF);
    expect_write("f0_l2", 10'd2, 16'h0000);
    expect_write("f0_l3", 10'd3, 16'hAAAA);
    repeat (2) @(posedge clk); #1;
    check_eq("f0_frame_done", fd_total, 32'd1);
    check_eq("f0_err",        32'(err_count), 32'd0);

    // Backpressure on row 0
    line_wr_ready = 1'b0;
    set_pix(24'hFFFFFF, 24'hFFFFFF);
    send_line(NW, 1'b1);
    @(posedge clk); #1;
    check_eq("bp_valid_0",  {31'b0, line_wr_valid}, 32'd1);
    check_eq("bp_data_0",   32'(line_data), 32'h0000FFFF);
    repeat (20) @(posedge clk); #1;
    check_eq("bp_tready",   {31'b0, sif.tready},    32'd0);
    check_eq("bp_valid_20", {31'b0, line_wr_valid}, 32'd1);
    check_eq("bp_data_20",  32'(line_data), 32'h0000FFFF);
    check_eq("bp_addr_20",  32'(line_addr), 32'd0);
    check_eq("bp_nowrite",  wr_total, 32'd4);
    line_wr_ready = 1'b1;
    expect_write("bp_l0", 10'd0, 16'hFFFF);

    // Short line on row 1: 9 words carry cells 0..11
    send_line(9, 1'b0);
    expect_write("short_l1", 10'd1, 16'hFFF0);
    check_eq("short_err", 32'(err_count), 32'd1);

    // Long line on row 2: 15 words, extras dropped, one write
    send_line(15, 1'b0);
    expect_write("long_l2", 10'd2, 16'hFFFF);
    check_eq("long_err", 32'(err_count), 32'd2);

    set_pix(24'hFFFFFF, 24'h000000);
    send_line(NW, 1'b0);
    expect_write("f1_l3", 10'd3, 16'hAAAA);
    repeat (2) @(posedge clk); #1;
    check_eq("f1_frame_done", fd_total, 32'd2);

    // Stray SOF partway through row 2 restarts at row 0
    set_pix(24'h000000, 24'h000000);       send_line(NW, 1'b1);
    set_pix(24'hFFFFFF, 24'h000000);       send_line(NW, 1'b0);
    set_pix(24'hFFFFFF, 24'hFFFFFF);
    pack_line();
    for (int unsigned i = 0; i < 5; i++) send_word(wbuf[i], 1'b0, 1'b0);
    pattern_line();                        send_line(NW, 1'b1);
    expect_write("f2_l0", 10'd0, 16'h0000);
    expect_write("f2_l1", 10'd1, 16'hAAAA);
    expect_write("stray_l0", 10'd0, 16'h9555);
    check_eq("stray_err", 32'(err_count), 32'd3);

    // Reset while a line waits for the writer
    line_wr_ready = 1'b0;
    set_pix(24'hFFFFFF, 24'hFFFFFF);
    send_line(NW, 1'b0);
    repeat (3) @(posedge clk); #1;
    check_eq("mw_valid", {31'b0, line_wr_valid}, 32'd1);
    check_eq("mw_addr",  32'(line_addr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mw_rst_valid",  {31'b0, line_wr_valid}, 32'd0);
    check_eq("mw_rst_tready", {31'b0, sif.tready},    32'd0);
    check_eq("mw_rst_err",    32'(err_count),         32'd0);
    check_eq("mw_rst_addr",   32'(line_addr),         32'd0);
    check_eq("mw_rst_data",   32'(line_data),         32'd0);
    check_eq("mw_rst_frame",  {31'b0, frame_done},    32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    line_wr_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check_eq("post_rst_tready", {31'b0, sif.tready}, 32'd1);
    check_eq("no_extra_writes", 32'(wa_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
